// File: rtl/position_move_controller.sv
// Encoder-tracked position counter with a closed-loop move sequencer:
// drive toward a latched target, settle on it, and flag stalls as errors.
module position_move_controller #(
  parameter int POS_W          = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_step_pol,
  input  logic             i_start,
  input  logic [POS_W-1:0] i_target,
  input  logic             i_abort,
  input  logic             i_zero,
  output logic [POS_W-1:0] o_position,
  output logic             o_motor_en,
  output logic             o_motor_dir,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STALL_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, ERROR} state_t;

  state_t              state_reg;
  logic [POS_W-1:0]    target_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [STALL_W-1:0]  stall_reg;
  logic [POS_W-1:0]    position_next;

  // Zero overrides a coincident step; arithmetic wraps naturally.
  always_comb begin
    position_next = o_position;
    if (i_zero)
      position_next = '0;
    else if (i_step)
      position_next = i_step_pol ? o_position + POS_W'(1) : o_position - POS_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      target_reg  <= '0;
      settle_reg  <= '0;
      stall_reg   <= '0;
      o_position  <= '0;
      o_motor_en  <= 1'b0;
      o_motor_dir <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_position <= position_next;
      o_done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            target_reg <= i_target;
            if (i_target == o_position) begin
              o_done <= 1'b1;
            end else begin
              state_reg   <= MOVE;
              stall_reg   <= '0;
              o_motor_en  <= 1'b1;
              o_busy      <= 1'b1;
              o_motor_dir <= $signed(i_target) > $signed(position_next);
            end
          end
        end
        MOVE: begin
          if (i_abort) begin
            state_reg   <= IDLE;
            o_motor_en  <= 1'b0;
            o_motor_dir <= 1'b0;
            o_busy      <= 1'b0;
          end else if (o_position == target_reg) begin
            state_reg   <= SETTLE;
            settle_reg  <= '0;
            o_motor_en  <= 1'b0;
            o_motor_dir <= 1'b0;
          end else if (!i_step && stall_reg == STALL_LAST) begin
            state_reg   <= ERROR;
            o_motor_en  <= 1'b0;
            o_motor_dir <= 1'b0;
            o_busy      <= 1'b0;
            o_error     <= 1'b1;
          end else begin
            stall_reg   <= i_step ? '0 : stall_reg + STALL_W'(1);
            // Tracking the post-step position lets an overshoot reverse drive.
            o_motor_dir <= $signed(target_reg) > $signed(position_next);
          end
        end
        SETTLE: begin
          if (i_abort) begin
            state_reg <= IDLE;
            o_busy    <= 1'b0;
          end else if (o_position != target_reg) begin
            state_reg   <= MOVE;
            stall_reg   <= '0;
            settle_reg  <= '0;
            o_motor_en  <= 1'b1;
            o_motor_dir <= $signed(target_reg) > $signed(position_next);
          end else if (settle_reg == SETTLE_LAST) begin
            state_reg  <= IDLE;
            settle_reg <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
          end else begin
            settle_reg <= settle_reg + SETTLE_W'(1);
          end
        end
        ERROR: begin
          if (i_abort) begin
            state_reg <= IDLE;
            o_error   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/position_move_controller.md
POSITION_MOVE_CONTROLLER -- requirements
Module: position_move_controller

Interface
REQ-001 Parameter POS_W, default 16, width of signed position and target.
REQ-002 Parameter SETTLE_CYCLES, default 8, cycles position must stay on target before completion.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, max cycles without a step while moving before error.
REQ-004 i_clk  in  1  master clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_step  in  1  single-cycle encoder step pulse.
REQ-007 i_step_pol  in  1  step polarity, valid with i_step; 1 = forward (+1), 0 = reverse (-1).
REQ-008 i_start  in  1  move request; sampled only in IDLE.
REQ-009 i_target  in  POS_W  signed target position, latched on accepted i_start.
REQ-010 i_abort  in  1  cancel move or clear error.
REQ-011 i_zero  in  1  synchronous clear of position counter.
REQ-012 o_position  out  POS_W  signed position counter.
REQ-013 o_motor_en  out  1  motor drive enable.
REQ-014 o_motor_dir  out  1  drive direction; 1 = forward.
REQ-015 o_busy  out  1  high in MOVE and SETTLE.
REQ-016 o_done  out  1  one-cycle pulse on successful completion.
REQ-017 o_error  out  1  high while in ERROR.

Function
REQ-018 Position: +1 on i_step with i_step_pol=1, -1 with i_step_pol=0, updated the cycle after the pulse; two's-complement wrap (max+1 -> min, min-1 -> max), no saturation.
REQ-019 i_zero sets position to 0 next cycle, overriding a simultaneous i_step; permitted in any state.
REQ-020 States: IDLE, MOVE, SETTLE, ERROR; all outputs registered.
REQ-021 IDLE: i_start latches i_target; if latched target equals current o_position -> o_done pulses next cycle, stay IDLE; else -> MOVE.
REQ-022 i_start outside IDLE is ignored; latched target unchanged.
REQ-023 MOVE: o_motor_en=1; o_motor_dir=1 when target > o_position (signed compare), else 0; direction re-evaluated every cycle so overshoot reverses drive.
REQ-024 MOVE: o_position == target -> SETTLE, o_motor_en=0 from that transition.
REQ-025 MOVE: stall counter clears on every i_step, increments otherwise; reaching TIMEOUT_CYCLES -> ERROR.
REQ-026 SETTLE: o_motor_en=0; settle counter increments each cycle position equals target; position leaving target -> MOVE, settle counter cleared, stall counter cleared.
REQ-027 SETTLE: counter reaching SETTLE_CYCLES -> IDLE with o_done one-cycle pulse.
REQ-028 ERROR: o_motor_en=0, o_error=1; exits to IDLE only on i_abort; i_start ignored.
REQ-029 i_abort in MOVE or SETTLE -> IDLE next cycle, o_motor_en=0, no o_done; i_abort in IDLE no effect.
REQ-030 Simultaneous i_abort and completion/timeout in same cycle: i_abort wins (IDLE, no o_done, no o_error).
REQ-031 Steps are counted in every state, including IDLE and ERROR.

Reset
REQ-032 Reset: state IDLE, o_position=0, target=0, all counters 0, o_motor_en=0, o_motor_dir=0, o_busy=0, o_done=0, o_error=0.
REQ-033 Reset asserted mid-move forces reset values immediately, no o_done or o_error.

Verification
REQ-034 i_start, i_target=5, five forward steps -> o_motor_en=1, o_motor_dir=1 until o_position=5, SETTLE 8 cycles, single o_done, o_busy low.
REQ-035 i_target=-3 from 0, four reverse steps then one forward -> o_motor_dir flips to 1 at -4, completion at -3 with one o_done.
REQ-036 i_start, i_target=10, no steps for 1000 cycles -> o_error=1, o_motor_en=0; i_start ignored; i_abort -> IDLE, o_error=0.
REQ-037 o_position=32767 (POS_W=16), forward step -> -32768; i_zero with simultaneous step -> 0.
REQ-038 i_start with i_target equal to o_position -> o_done next cycle, o_motor_en never asserted.
REQ-039 In SETTLE at cycle 4 a reverse step -> back to MOVE, dir=1; after return, full 8-cycle settle before o_done.
